// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIG_W = 4;

  // Counter width for BIN_W iterations; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more, carry dropped.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, BIN_W cycles per operand.
// Handshake: start is taken only while ready=1; done_tick pulses one cycle with bcd valid.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 7,
  parameter int NDIG  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIN_W-1:0]       bin,
  output logic                   ready,
  output logic                   done_tick,
  output logic [DIG_W*NDIG-1:0]  bcd
);

  localparam int CNT_W = clog2(BIN_W);
  localparam int BCD_W = DIG_W * NDIG;

  if (10**NDIG <= 2**BIN_W - 1) begin : g_bad_params
    $error("bin2bcd_seq: NDIG too small for BIN_W");
  end

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_shift;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   bcd_corr;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [BCD_W-1:0]   bcd_q;
  logic               unused_corr_msb;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_work[g*DIG_W +: DIG_W]),
      .dout (bcd_corr[g*DIG_W +: DIG_W])
    );
  end

  // Top corrected bit falls off the shift; the parameter check keeps it zero.
  assign bcd_shifted     = {bcd_corr[BCD_W-2:0], bin_shift[BIN_W-1]};
  assign unused_corr_msb = bcd_corr[BCD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = OP;
      OP:      if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bin_shift <= '0;
      bcd_work  <= '0;
      bcd_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_shift <= bin;
            bcd_work  <= '0;
            cnt       <= CNT_W'(BIN_W - 1);
          end
        end
        OP: begin
          bcd_work  <= bcd_shifted;
          bin_shift <= bin_shift << 1;
          if (cnt == '0) bcd_q <= bcd_shifted;
          else           cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign done_tick = (state == DONE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed scenarios plus random operands against a decimal-digit model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 7;
  localparam int NDIG  = 3;
  localparam int BCD_W = 4 * NDIG;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             ready;
  logic             done_tick;
  logic [BCD_W-1:0] bcd;

  int               checks = 0;
  int               failures = 0;
  logic [BCD_W-1:0] exp_q[$];
  logic [BCD_W-1:0] last_bcd = '0;

  bin2bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference: decimal digits by division, least significant digit in bits [3:0]
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  // driver: one conversion, checked for hold, latency, value and return to idle
  task automatic convert(input int v);
    int lat;
    logic [BCD_W-1:0] exp;
    wait_ready();
    start = 1'b1;
    bin   = BIN_W'(v);
    exp_q.push_back(ref_bcd(v));
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'($urandom);
    lat   = 0;
    check("bcd_hold_op", 32'(bcd), 32'(last_bcd));
    while (done_tick !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, BIN_W);
    exp = exp_q.pop_front();
    check("bcd_value", 32'(bcd), 32'(exp));
    last_bcd = exp;
    @(negedge clk);
    check("ready_after_done", 32'(ready), 32'd1);
    check("done_one_cycle", 32'(done_tick), 32'd0);
  endtask

  initial begin
    int ticks;
    bit prev_done;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    rst_n = 1'b1;

    // directed values
    convert(0);
    convert(99);
    convert(127);
    convert(10);
    convert(5 * 10 + 7);

    // sweep of two-digit values
    for (int v = 0; v < 100; v++) convert(v);

    // start kept high with a new operand while busy: only the first is taken
    wait_ready();
    start = 1'b1;
    bin   = 7'd33;
    @(negedge clk);
    bin = 7'd88;
    repeat (3) @(negedge clk);
    start = 1'b0;
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_tick === 1'b1) begin
        ticks++;
        check("busy_bcd", 32'(bcd), 32'(ref_bcd(33)));
      end
      @(negedge clk);
    end
    check("busy_ticks", ticks, 1);
    last_bcd = ref_bcd(33);
    convert(88);

    // asynchronous reset in the middle of a conversion
    wait_ready();
    start = 1'b1;
    bin   = 7'd127;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done_tick), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    last_bcd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_tick === 1'b1) ticks++;
      @(negedge clk);
    end
    check("midrst_no_tick", ticks, 0);
    convert(45);

    // start held high: back-to-back conversions of the same operand
    wait_ready();
    bin   = 7'd64;
    start = 1'b1;
    ticks = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (prev_done) check("held_ready", 32'(ready), 32'd1);
      prev_done = (done_tick === 1'b1);
      if (prev_done) begin
        ticks++;
        check("held_bcd", 32'(bcd), 32'(ref_bcd(64)));
      end
    end
    start = 1'b0;
    check("held_ticks", 32'(ticks >= 3), 32'd1);
    last_bcd = ref_bcd(64);
    repeat (12) @(negedge clk);

    // random operands over the full input range
    for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 127)));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
